// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Two-port (fetch / load-store) arbiter onto a single-outstanding
//            memory port, with data priority and fetch starvation protection.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,

    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,

    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [3:0]  ls_be_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    logic [1:0]       r_state;
    logic             r_owner;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_we;
    logic [3:0]       r_be;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;

    logic w_idle;
    logic w_fetch_wins;
    logic w_if_gnt;
    logic w_ls_gnt;
    logic w_rsp;

    // Fetch only beats a pending data request once it has been starved long enough.
    assign w_idle       = (r_state == IDLE);
    assign w_fetch_wins = if_req_i && (!ls_req_i || (r_starve_cnt == LIMIT));
    assign w_if_gnt     = rstn_i && w_idle && w_fetch_wins;
    assign w_ls_gnt     = rstn_i && w_idle && ls_req_i && !w_fetch_wins;
    assign w_rsp        = rstn_i && (r_state == WAIT) && mem_rvalid_i;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state      <= IDLE;
            r_owner      <= OWNER_FETCH;
            r_starve_cnt <= '0;
            r_we         <= 1'b0;
            r_be         <= 4'b0000;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_if_gnt) begin
                        r_state      <= ISSUE;
                        r_owner      <= OWNER_FETCH;
                        r_starve_cnt <= '0;
                        r_we         <= 1'b0;
                        r_be         <= 4'b1111;
                        r_addr       <= if_addr_i;
                        r_wdata      <= 32'h0;
                    end else if (w_ls_gnt) begin
                        r_state <= ISSUE;
                        r_owner <= OWNER_DATA;
                        r_we    <= ls_we_i;
                        r_be    <= ls_be_i;
                        r_addr  <= ls_addr_i;
                        r_wdata <= ls_wdata_i;
                        if (!if_req_i) begin
                            r_starve_cnt <= '0;
                        end else if (r_starve_cnt != LIMIT) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_gnt_i) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign if_gnt_o    = w_if_gnt;
    assign ls_gnt_o    = w_ls_gnt;
    assign if_rvalid_o = w_rsp && (r_owner == OWNER_FETCH);
    assign ls_rvalid_o = w_rsp && (r_owner == OWNER_DATA);
    assign if_rdata_o  = mem_rdata_i;
    assign ls_rdata_o  = mem_rdata_i;

    assign mem_req_o   = rstn_i && (r_state == ISSUE);
    assign mem_we_o    = r_we;
    assign mem_be_o    = r_be;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, the number of consecutive data grants allowed while fetch waits before fetch is forced ahead.
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clk_i  in  1  clock; all state updates on rising edge.
REQ-004 rstn_i  in  1  synchronous active-low reset.
REQ-005 if_req_i  in  1  fetch request; held with if_addr_i stable until if_gnt_o.
REQ-006 if_addr_i  in  32  fetch word address.
REQ-007 if_gnt_o  out  1  one-cycle pulse, fetch request accepted.
REQ-008 if_rvalid_o  out  1  one-cycle pulse, fetch data valid on if_rdata_o.
REQ-009 if_rdata_o  out  32  fetch read data.
REQ-010 ls_req_i  in  1  load/store request; held with ls_we_i, ls_be_i, ls_addr_i, ls_wdata_i stable until ls_gnt_o.
REQ-011 ls_we_i  in  1  1 = store, 0 = load.
REQ-012 ls_be_i  in  4  store byte enables.
REQ-013 ls_addr_i  in  32  data address.
REQ-014 ls_wdata_i  in  32  store data.
REQ-015 ls_gnt_o  out  1  one-cycle pulse, data request accepted.
REQ-016 ls_rvalid_o  out  1  one-cycle pulse, load data valid or store complete.
REQ-017 ls_rdata_o  out  32  load read data.
REQ-018 mem_req_o  out  1  memory request; held until mem_gnt_i.
REQ-019 mem_we_o  out  1  memory write enable; mem_be_o  out  4; mem_addr_o  out  32; mem_wdata_o  out  32.
REQ-020 mem_gnt_i  in  1  memory accepted request this cycle.
REQ-021 mem_rvalid_i  in  1  response pulse; never earlier than the cycle after mem_gnt_i.
REQ-022 mem_rdata_i  in  32  response data.

Function
REQ-023 FSM states: IDLE, ISSUE, WAIT; owner register: FETCH or DATA; one outstanding transaction maximum.
REQ-024 IDLE, no request pending: stay in IDLE; all pulse outputs 0; mem_req_o 0.
REQ-025 IDLE, request pending: choose a winner, assert its gnt_o combinationally in the same cycle, latch its attributes and the owner at the edge, go to ISSUE.
REQ-026 Priority when both requests pend: DATA wins, unless the starvation counter equals STARVE_LIMIT, in which case FETCH wins.
REQ-027 Fetch attributes latched: we=0, be=4'b1111, wdata=0.
REQ-028 Starvation counter (width clog2(STARVE_LIMIT+1)) behaviour:
  - increments on a DATA grant while if_req_i=1;
  - clears on a FETCH grant;
  - clears on a DATA grant while if_req_i=0;
  - saturates at STARVE_LIMIT.
REQ-029 ISSUE: mem_req_o=1 with latched attributes; on mem_gnt_i=1 go to WAIT, otherwise stay in ISSUE with attributes unchanged.
REQ-030 WAIT: mem_req_o=0; on mem_rvalid_i=1, pulse the owner's rvalid_o in the same cycle and go to IDLE.
REQ-031 Stores also complete via mem_rvalid_i (write acknowledge); ls_rvalid_o pulses for a store as for a load.
REQ-032 if_rdata_o and ls_rdata_o SHALL equal mem_rdata_i at all times; only rvalid_o qualifies them.
REQ-033 mem_rvalid_i in IDLE or ISSUE is ignored: no rvalid_o, no state change.
REQ-034 gnt_o is never asserted outside IDLE; a requester's gnt_o and rvalid_o never assert in the same cycle.
REQ-035 Minimum transaction is 3 cycles: grant in IDLE, then ISSUE, then WAIT with rvalid; back-to-back grant no earlier than the cycle after rvalid.
REQ-036 Requests that drop before grant are not remembered.

Reset
REQ-037 rstn_i=0 at an edge forces the following, regardless of state (mid-transaction aborted, pending response discarded):
  - state to IDLE;
  - owner to FETCH;
  - starvation counter to 0;
  - latched attributes to 0.
REQ-038 Output values during and after reset: mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, if_gnt_o=0, ls_gnt_o=0, if_rvalid_o=0, ls_rvalid_o=0.

Verification
REQ-039 Single fetch test:
  - stimulus: if_req_i=1, if_addr_i=0x100; mem_gnt_i immediately; mem_rvalid_i two cycles later with rdata=0xDEADBEEF;
  - response: if_gnt_o in cycle 0; mem_req_o with addr 0x100 and we=0 in cycle 1; if_rvalid_o with if_rdata_o=0xDEADBEEF in cycle 3.
REQ-040 Collision test:
  - stimulus: if_req_i and ls_req_i (store, addr 0x200, be 4'b0011, wdata 0x1234) both raised in IDLE;
  - response: ls_gnt_o first; mem_we_o=1, mem_be_o=4'b0011; ls_rvalid_o pulses; fetch granted in the IDLE cycle following.
REQ-041 Starvation test:
  - stimulus: if_req_i held high, ls_req_i re-asserted continuously, STARVE_LIMIT=4;
  - response: exactly 4 DATA grants, then a FETCH grant, then the counter is 0.
REQ-042 Memory stall test:
  - stimulus: mem_gnt_i held low 5 cycles in ISSUE, with ls_addr_i changed after grant;
  - response: mem_req_o held and mem_addr_o unchanged for all 5 cycles; no gnt_o pulses.
REQ-043 Reset mid-transaction test:
  - stimulus: rstn_i=0 in WAIT, then mem_rvalid_i after reset release;
  - response: all outputs 0; state IDLE; no rvalid_o pulse.
REQ-044 Stray response test:
  - stimulus: mem_rvalid_i pulsed in IDLE;
  - response: no rvalid_o; no state change.
